// File: rtl/mem_port_arbiter.sv
// Memory-side responder for the pipeline stall handshake: arbitrates the fetch and
// data ports onto one variable-latency backing bus and holds each result until advance.
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req1,
    input  logic [AW-1:0]   addr1,
    output logic [DW-1:0]   rdata1,
    output logic            memValid1,
    input  logic            req2,
    input  logic            we2,
    input  logic [AW-1:0]   addr2,
    input  logic [DW-1:0]   wdata2,
    input  logic [DW/8-1:0] be2,
    output logic [DW-1:0]   rdata2,
    output logic            memValid2,
    output logic            bus_req,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_be,
    input  logic            bus_ack,
    input  logic [DW-1:0]   bus_rdata,
    output logic            bus_err
);

    localparam int BW = DW / 8;
    // Count value during the last permitted wait cycle; the counter clears on bus entry.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS_D = 2'd1,
        ST_BUS_I = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic            done1_r;
    logic            done2_r;
    logic [7:0]      wait_cnt_r;
    logic [DW-1:0]   rdata1_r;
    logic [DW-1:0]   rdata2_r;
    logic            bus_req_r;
    logic            bus_we_r;
    logic [AW-1:0]   bus_addr_r;
    logic [DW-1:0]   bus_wdata_r;
    logic [BW-1:0]   bus_be_r;
    logic            bus_err_r;
    logic            issue_d_s;
    logic            issue_i_s;
    logic            finish_s;
    logic            timeout_s;
    logic            advance_s;
    logic            mem_valid1_s;
    logic            mem_valid2_s;

    assign mem_valid1_s = ~req1 | done1_r;
    assign mem_valid2_s = ~req2 | done2_r;
    assign advance_s    = mem_valid1_s & mem_valid2_s;

    assign memValid1 = mem_valid1_s;
    assign memValid2 = mem_valid2_s;
    assign rdata1    = rdata1_r;
    assign rdata2    = rdata2_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;
    assign bus_be    = bus_be_r;
    assign bus_err   = bus_err_r;

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and control strobes; the data port wins because it holds the older instruction
    always_comb begin
        state_nxt_s = state_r;
        issue_d_s   = 1'b0;
        issue_i_s   = 1'b0;
        finish_s    = 1'b0;
        timeout_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req2 && !done2_r) begin
                    state_nxt_s = ST_BUS_D;
                    issue_d_s   = 1'b1;
                end else if (req1 && !done1_r) begin
                    state_nxt_s = ST_BUS_I;
                    issue_i_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUS_D, ST_BUS_I: begin
                if (bus_ack) begin
                    finish_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    finish_s    = 1'b1;
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Backing-bus request registers and timeout pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= {AW{1'b0}};
            bus_wdata_r <= {DW{1'b0}};
            bus_be_r    <= {BW{1'b0}};
            bus_err_r   <= 1'b0;
        end else begin
            bus_err_r <= timeout_s;
            if (issue_d_s) begin
                bus_req_r   <= 1'b1;
                bus_we_r    <= we2;
                bus_addr_r  <= addr2;
                bus_wdata_r <= wdata2;
                bus_be_r    <= we2 ? be2 : {BW{1'b1}};
            end else if (issue_i_s) begin
                bus_req_r   <= 1'b1;
                bus_we_r    <= 1'b0;
                bus_addr_r  <= addr1;
                bus_wdata_r <= {DW{1'b0}};
                bus_be_r    <= {BW{1'b1}};
            end else if (finish_s) begin
                bus_req_r <= 1'b0;
            end
        end
    end

    // Bus wait counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= 8'd0;
        end else if (issue_d_s || issue_i_s) begin
            wait_cnt_r <= 8'd0;
        end else if ((state_r != ST_IDLE) && !finish_s) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
        end
    end

    // Completion flags and result capture; a port that dropped its request discards the result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done1_r  <= 1'b0;
            done2_r  <= 1'b0;
            rdata1_r <= {DW{1'b0}};
            rdata2_r <= {DW{1'b0}};
        end else begin
            if (advance_s) begin
                done1_r <= 1'b0;
                done2_r <= 1'b0;
            end
            if (finish_s && (state_r == ST_BUS_I) && req1) begin
                done1_r  <= 1'b1;
                rdata1_r <= timeout_s ? {DW{1'b0}} : bus_rdata;
            end
            if (finish_s && (state_r == ST_BUS_D) && req2) begin
                done2_r <= 1'b1;
                if (!bus_we_r) begin
                    rdata2_r <= timeout_s ? {DW{1'b0}} : bus_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all checked each cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req1 = 1'b0;
    logic [AW-1:0] addr1 = 32'd0;
    logic [DW-1:0] rdata1;
    logic          memValid1;
    logic          req2 = 1'b0;
    logic          we2 = 1'b0;
    logic [AW-1:0] addr2 = 32'd0;
    logic [DW-1:0] wdata2 = 32'd0;
    logic [BW-1:0] be2 = 4'd0;
    logic [DW-1:0] rdata2;
    logic          memValid2;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [BW-1:0] bus_be;
    logic          bus_ack = 1'b0;
    logic [DW-1:0] bus_rdata = 32'd0;
    logic          bus_err;

    mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .req1(req1), .addr1(addr1), .rdata1(rdata1), .memValid1(memValid1),
        .req2(req2), .we2(we2), .addr2(addr2), .wdata2(wdata2), .be2(be2),
        .rdata2(rdata2), .memValid2(memValid2),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_be(bus_be), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: which port owns the bus (0 none, 1 fetch, 2 data) and the results.
    int            m_busy;
    int            m_waits;
    logic          m_done1, m_done2;
    logic [31:0]   m_rdata1, m_rdata2;
    logic          m_bus_req, m_bus_we, m_bus_err;
    logic [31:0]   m_bus_addr, m_bus_wdata;
    logic [3:0]    m_bus_be;

    // Bus responder knobs and per-cycle observations
    int   ack_lat = 0;
    int   resp_cnt = 0;
    logic idle_ack = 1'b0;
    logic s_mv1, s_mv2, s_breq, s_berr, s_we, s_ack;
    logic [3:0] s_be;

    function automatic logic [31:0] rpat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_waits = 0; m_done1 = 1'b0; m_done2 = 1'b0;
        m_rdata1 = 32'd0; m_rdata2 = 32'd0;
        m_bus_req = 1'b0; m_bus_we = 1'b0; m_bus_err = 1'b0;
        m_bus_addr = 32'd0; m_bus_wdata = 32'd0; m_bus_be = 4'd0;
        resp_cnt = 0;
    endtask

    // One clock cycle: drive bus response, check outputs against model, advance model.
    task automatic step();
        logic e_mv1, e_mv2, adv, tmo;
        int   n_busy, n_waits, w;
        logic n_done1, n_done2, n_req, n_we, n_err;
        logic [31:0] n_r1, n_r2, n_addr, n_wdata, rv;
        logic [3:0] n_be;
        bus_ack   = (bus_req === 1'b1) ? (resp_cnt >= ack_lat) : idle_ack;
        bus_rdata = bus_ack ? rpat(bus_addr) : $urandom();
        #1;
        e_mv1 = !req1 || m_done1;
        e_mv2 = !req2 || m_done2;
        chk("memValid1", {31'd0, memValid1}, {31'd0, e_mv1});
        chk("memValid2", {31'd0, memValid2}, {31'd0, e_mv2});
        chk("bus_req", {31'd0, bus_req}, {31'd0, m_bus_req});
        chk("bus_err", {31'd0, bus_err}, {31'd0, m_bus_err});
        chk("rdata1", rdata1, m_rdata1);
        chk("rdata2", rdata2, m_rdata2);
        if (m_bus_req) begin
            chk("bus_addr", bus_addr, m_bus_addr);
            chk("bus_we", {31'd0, bus_we}, {31'd0, m_bus_we});
            chk("bus_be", {28'd0, bus_be}, {28'd0, m_bus_be});
            if (m_bus_we) chk("bus_wdata", bus_wdata, m_bus_wdata);
        end
        s_mv1 = memValid1; s_mv2 = memValid2; s_breq = bus_req; s_berr = bus_err;
        s_we = bus_we; s_be = bus_be; s_ack = bus_ack;

        adv = e_mv1 && e_mv2;
        n_busy = m_busy; n_waits = m_waits; n_req = m_bus_req; n_we = m_bus_we;
        n_addr = m_bus_addr; n_wdata = m_bus_wdata; n_be = m_bus_be; n_err = 1'b0;
        n_r1 = m_rdata1; n_r2 = m_rdata2;
        n_done1 = adv ? 1'b0 : m_done1;
        n_done2 = adv ? 1'b0 : m_done2;
        if (m_busy == 0) begin
            if (req2 && !m_done2) begin
                n_busy = 2; n_waits = 0; n_req = 1'b1; n_addr = addr2; n_we = we2;
                n_be = we2 ? be2 : 4'hF; n_wdata = wdata2;
            end else if (req1 && !m_done1) begin
                n_busy = 1; n_waits = 0; n_req = 1'b1; n_addr = addr1; n_we = 1'b0;
                n_be = 4'hF;
            end
        end else begin
            w = m_waits + 1;
            if (bus_ack || w == TO) begin
                tmo = !bus_ack;
                rv = tmo ? 32'd0 : rpat(m_bus_addr);
                n_busy = 0; n_req = 1'b0; n_err = tmo;
                if (m_busy == 1 && req1) begin
                    n_done1 = 1'b1; n_r1 = rv;
                end
                if (m_busy == 2 && req2) begin
                    n_done2 = 1'b1;
                    if (!m_bus_we) n_r2 = rv;
                end
            end else begin
                n_waits = w;
            end
        end
        @(posedge clk);
        #1;
        m_busy = n_busy; m_waits = n_waits; m_done1 = n_done1; m_done2 = n_done2;
        m_rdata1 = n_r1; m_rdata2 = n_r2; m_bus_req = n_req; m_bus_we = n_we;
        m_bus_addr = n_addr; m_bus_wdata = n_wdata; m_bus_be = n_be; m_bus_err = n_err;
        resp_cnt = (s_breq && !s_ack) ? resp_cnt + 1 : 0;
    endtask

    initial begin
        int low, pulses, t1, t2, errs;
        logic prev_breq, seen_we;
        logic [3:0] seen_be;
        logic [31:0] prev_r;

        // Reset state
        model_reset();
        #1;
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_rdata1", rdata1, 32'd0);
        chk("rst_rdata2", rdata2, 32'd0);
        chk("rst_memValid1", {31'd0, memValid1}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        step();

        // Fetch only, ack one cycle after bus_req
        req1 = 1'b1; addr1 = 32'h0000_1000; ack_lat = 1; low = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!s_mv1) low++;
            else break;
        end
        chk("fetch_low_cycles", low, 32'd3);
        chk("fetch_rdata1", rdata1, rpat(32'h0000_1000));
        chk("fetch_done_cleared", {31'd0, memValid1}, 32'd0);
        req1 = 1'b0;
        step();

        // Both ports at once, ack latency 2
        req1 = 1'b1; req2 = 1'b1; we2 = 1'b0; addr1 = 32'h0000_1100; addr2 = 32'h0000_2200;
        ack_lat = 2; pulses = 0; t1 = -1; t2 = -1; prev_breq = 1'b0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (s_breq && !prev_breq) pulses++;
            prev_breq = s_breq;
            if (s_mv2 && t2 < 0) t2 = c;
            if (s_mv1 && t1 < 0) t1 = c;
            if (s_mv1 && s_mv2) break;
        end
        chk("data_first", {31'd0, (t2 >= 0 && t1 > t2)}, 32'd1);
        chk("two_bus_pulses", pulses, 32'd2);
        req1 = 1'b0; req2 = 1'b0;
        step();

        // Store with partial byte enables
        prev_r = m_rdata2;
        req2 = 1'b1; we2 = 1'b1; be2 = 4'b0011; wdata2 = 32'hDEAD_BEEF; addr2 = 32'h0000_3300;
        ack_lat = 0; seen_we = 1'b0; seen_be = 4'd0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (s_breq) begin
                seen_we = s_we; seen_be = s_be;
            end
            if (s_mv2) break;
        end
        chk("store_we", {31'd0, seen_we}, 32'd1);
        chk("store_be", {28'd0, seen_be}, 32'h3);
        chk("store_rdata2", rdata2, prev_r);
        req2 = 1'b0; we2 = 1'b0;
        step();

        // Timeout: no ack ever
        req1 = 1'b1; addr1 = 32'h0000_4400; ack_lat = 1000; errs = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (s_berr) errs++;
            if (s_mv1) break;
        end
        chk("timeout_rdata1", rdata1, 32'd0);
        req1 = 1'b0;
        step();
        if (s_berr) errs++;
        step();
        if (s_berr) errs++;
        chk("timeout_err_pulses", errs, 32'd1);

        // Reset asserted during a data-port bus operation
        req2 = 1'b1; we2 = 1'b0; addr2 = 32'h0000_5500; ack_lat = 1000;
        step();
        step();
        chk("pre_rst_bus_req", {31'd0, bus_req}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_bus_req", {31'd0, bus_req}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("post_rst_memValid2", {31'd0, memValid2}, 32'd0);
        chk("post_rst_memValid1", {31'd0, memValid1}, 32'd1);
        chk("post_rst_bus_req", {31'd0, bus_req}, 32'd0);
        req2 = 1'b0;
        step();
        step();

        // Fetch request withdrawn while the bus op is in flight
        prev_r = m_rdata1;
        req1 = 1'b1; addr1 = 32'h0000_6600; ack_lat = 3;
        step();
        step();
        req1 = 1'b0; pulses = 0; prev_breq = s_breq;
        for (int c = 0; c < 8; c++) begin
            step();
            if (s_breq && !prev_breq) pulses++;
            prev_breq = s_breq;
        end
        chk("drop_rdata1", rdata1, prev_r);
        chk("drop_no_reissue", pulses, 32'd0);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            if (!bus_req) ack_lat = $urandom_range(0, 5);
            idle_ack = ($urandom_range(0, 3) == 0);
            if ((!req1 || m_done1) && (!req2 || m_done2)) begin
                req1 = ($urandom_range(0, 3) != 0);
                req2 = ($urandom_range(0, 3) != 0);
                we2  = 1'($urandom_range(0, 1));
                be2  = 4'($urandom());
            end else begin
                if ($urandom_range(0, 31) == 0) req1 = 1'b0;
                if ($urandom_range(0, 31) == 0) req2 = 1'b0;
            end
            addr1 = $urandom(); addr2 = $urandom(); wdata2 = $urandom();
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
